// File: rtl/pipe_pkg.sv
// Shared types and constants for the stage-4 hit serializer.
//   PARALLEL_SIZE : lanes per input beat
//   PARA          : width of each per-lane index J
//   lane_idx_t    : lane number (0..PARALLEL_SIZE-1)
//   j_vec_t       : one beat of per-lane J values, packed lane-major
//   pipe_s4_state_e : serializer FSM states
package pipe_pkg;

    localparam int PARALLEL_SIZE = 12;
    localparam int PARA          = 16;

    typedef logic [3:0] lane_idx_t;
    typedef logic [PARALLEL_SIZE-1:0][PARA-1:0] j_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } pipe_s4_state_e;

endpackage

// File: rtl/lane_prio_enc.sv
// Combinational lowest-set-bit encoder over a lane mask.
//   mask   : lane mask to search
//   idx    : lowest set lane (0 when mask is empty)
//   any    : mask has at least one bit set
//   onehot : mask has exactly one bit set
module lane_prio_enc
    import pipe_pkg::*;
(
    input  logic [PARALLEL_SIZE-1:0] mask,
    output lane_idx_t                idx,
    output logic                     any,
    output logic                     onehot
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set lane wins.
        for (int i = PARALLEL_SIZE - 1; i >= 0; i--) begin
            if (mask[i]) idx = lane_idx_t'(i);
        end
    end

    assign any    = |mask;
    // Clearing the lowest set bit leaves nothing iff exactly one bit was set.
    assign onehot = any && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/pipe_stage4_serialize.sv
// Stage-4 serializer: accepts one PARALLEL_SIZE-lane beat of
// (out-of-interval flag, J) and emits the J of each flagged lane, one per
// cycle in ascending lane order, on a valid/ready stream. Keeps a saturating
// count of emitted hits.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input beat handshake
//   flag_i, J_i       : per-lane flag and index from stage 3
//   out_valid/out_ready : output handshake
//   out_idx, out_lane : J and lane number of the emitted hit
//   out_last          : last flagged lane of the current beat
//   hit_cnt, clear_i  : saturating hit counter and its synchronous clear
module pipe_stage4_serialize
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PARALLEL_SIZE-1:0] flag_i,
    input  j_vec_t                   J_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PARA-1:0]          out_idx,
    output lane_idx_t                out_lane,
    output logic                     out_last,
    output logic [CNT_W-1:0]         hit_cnt,
    input  logic                     clear_i
);

    pipe_s4_state_e           state;
    logic [PARALLEL_SIZE-1:0] pend;
    j_vec_t                   jhold;

    lane_idx_t lo_idx;
    logic      pend_any;
    logic      pend_onehot;

    lane_prio_enc u_enc (
        .mask   (pend),
        .idx    (lo_idx),
        .any    (pend_any),
        .onehot (pend_onehot)
    );

    // All out_* are functions of registered state only; gated to zero when
    // idle so stale holding-register contents never leak out.
    assign out_valid = (state == DRAIN) && pend_any;
    assign out_lane  = out_valid ? lo_idx : '0;
    assign out_idx   = out_valid ? jhold[lo_idx] : '0;
    assign out_last  = out_valid && pend_onehot;

    logic hs, load;
    assign hs       = out_valid && out_ready;
    // Accept a new beat while idle, or in the same cycle the final hit of
    // the current beat handshakes, so consecutive beats have no bubble.
    assign in_ready = (state == IDLE) || (hs && out_last);
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            jhold   <= '0;
            hit_cnt <= '0;
        end else begin
            if (load) begin
                pend  <= flag_i;
                state <= (flag_i != '0) ? DRAIN : IDLE;
                if (flag_i != '0) jhold <= J_i;
            end else if (hs) begin
                // Drop the lane just emitted.
                pend <= pend & (pend - 1'b1);
                if (out_last) state <= IDLE;
            end

            // Clear wins over a coincident hit.
            if (clear_i)
                hit_cnt <= '0;
            else if (hs && (hit_cnt != {CNT_W{1'b1}}))
                hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage4_serialize.sv
// Self-checking bench for pipe_stage4_serialize. A queue-based reference
// model expands each accepted beat into its list of hits and compares the
// DUT stream against the queue head every cycle.
module tb_pipe_stage4_serialize;
    import pipe_pkg::*;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [PARALLEL_SIZE-1:0] flag_i;
    j_vec_t                   J_i;
    logic                     out_valid;
    logic                     out_ready;
    logic [PARA-1:0]          out_idx;
    lane_idx_t                out_lane;
    logic                     out_last;
    logic [CNT_W-1:0]         hit_cnt;
    logic                     clear_i;

    pipe_stage4_serialize #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flag_i    (flag_i),
        .J_i       (J_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .hit_cnt   (hit_cnt),
        .clear_i   (clear_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending hits of the beat being drained, plus count.
    int q_lane[$];
    int q_idx[$];
    bit q_last[$];
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs mid-cycle, advance the model by one clock, then step
    // the DUT. Inputs must already be set for this cycle.
    task automatic cycle();
        int  n;
        bit  exp_rdy;
        @(negedge clk);
        n       = q_lane.size();
        exp_rdy = (n == 0) || (out_ready && q_last[0]);
        chk("out_valid", 32'(out_valid), 32'(n != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
        if (n != 0) begin
            chk("out_lane", 32'(out_lane), 32'(q_lane[0]));
            chk("out_idx", 32'(out_idx), 32'(q_idx[0]));
            chk("out_last", 32'(out_last), 32'(q_last[0]));
        end

        if (rst) begin
            q_lane.delete(); q_idx.delete(); q_last.delete();
            m_cnt = 0;
        end else begin
            if (n != 0 && out_ready) begin
                void'(q_lane.pop_front()); void'(q_idx.pop_front()); void'(q_last.pop_front());
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (clear_i) m_cnt = 0;
            if (in_valid && exp_rdy) begin
                for (int k = 0; k < PARALLEL_SIZE; k++) begin
                    if (flag_i[k]) begin
                        q_lane.push_back(k);
                        q_idx.push_back(int'(J_i[k]));
                        q_last.push_back((flag_i >> (k + 1)) == 0);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_j_ramp();
        for (int k = 0; k < PARALLEL_SIZE; k++) J_i[k] = 16'h0100 + 16'(k);
    endtask

    task automatic set_j_rand();
        for (int k = 0; k < PARALLEL_SIZE; k++) J_i[k] = 16'($urandom);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_i = 1'b0;
        flag_i = '0; set_j_ramp();
        m_cnt = 0;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();

        // Empty beat is consumed with no output.
        in_valid = 1'b1; flag_i = 12'h000;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("zero_vec_cnt", 32'(hit_cnt), 32'd0);

        // 12'h825: lanes 0,2,5,11 back to back.
        in_valid = 1'b1; flag_i = 12'h825; set_j_ramp();
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();
        chk("cnt_after_825", 32'(hit_cnt), 32'd4);

        // Same beat with backpressure on cycles 2-4 after acceptance; input
        // noise during the stall must be ignored.
        in_valid = 1'b1; flag_i = 12'h825; set_j_ramp();
        cycle();
        flag_i = 12'h3C3;
        cycle();
        out_ready = 1'b0;
        repeat (3) begin
            set_j_rand();
            flag_i = 12'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        chk("cnt_after_stall", 32'(hit_cnt), 32'd8);

        // 12'h001 then 12'h800 with in_valid held: no bubble.
        set_j_ramp();
        in_valid = 1'b1; flag_i = 12'h001;
        cycle();
        flag_i = 12'h800;
        cycle();
        in_valid = 1'b0;
        chk("b2b_lane11", 32'(out_lane), 32'd11);
        cycle();
        cycle();
        chk("cnt_after_b2b", 32'(hit_cnt), 32'd10);

        // Clear alone, then count to 7 and clear on the 8th handshake.
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        in_valid = 1'b1; flag_i = 12'h0FF;
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();
        chk("cnt_seven", 32'(hit_cnt), 32'd7);
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        cycle();
        chk("clear_wins", 32'(hit_cnt), 32'd0);

        // Reset mid-drain of 12'hFFF after 3 beats.
        in_valid = 1'b1; flag_i = 12'hFFF;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(hit_cnt), 32'd0);
        repeat (3) cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear_i   = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            case ($urandom_range(0, 3))
                0:       flag_i = '0;
                1:       flag_i = 12'(1 << $urandom_range(0, PARALLEL_SIZE - 1));
                default: flag_i = 12'($urandom);
            endcase
            set_j_rand();
            cycle();
        end
        rst = 1'b0; clear_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (14) cycle();

        // Saturation: clear, then stream all-ones beats past 2^CNT_W-1 hits.
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        in_valid = 1'b1; flag_i = 12'hFFF; set_j_ramp();
        repeat (CNT_MAX + 40) cycle();
        chk("saturated", 32'(hit_cnt), 32'hFFFF);
        repeat (5) cycle();
        chk("still_saturated", 32'(hit_cnt), 32'hFFFF);
        in_valid = 1'b0;
        repeat (14) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
